fifo_burst_arbiter: RTL and testbench

Read-side arbiter and sequencer for the two camera-port line FIFOs in the 2-port MIPI capture path. It watches each FIFO's occupancy and grants one port at a time a burst of up to BURST_LEN words, driving that FIFO's read enable. It forwards the read words downstream, toward the framebuffer write master, through a valid/ready interface carrying port ID and burst-boundary markers. Between bursts it arbitrates round-robin, so neither camera can starve the other.

---
 rtl/fifo_burst_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_fifo_burst_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_arbiter.sv
// fifo_burst_arbiter: burst read sequencer for the two camera line FIFOs.
// Optional build macro FIFO_ARB_FIXED_PRIO_EN: port 0 always wins ties.
module fifo_burst_arbiter #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8,
   parameter int BURST_LEN  = 32
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic [ADDR_WIDTH:0]   cnt0,
   input  logic [ADDR_WIDTH:0]   cnt1,
   input  logic                  flush0,
   input  logic                  flush1,
   output logic                  re0,
   output logic                  re1,
   input  logic [DATA_WIDTH-1:0] rdata0,
   input  logic [DATA_WIDTH-1:0] rdata1,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_port,
   output logic                  out_first,
   output logic                  out_last,
   output logic                  busy
);
   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0] BLEN = CW'(BURST_LEN);
   localparam logic [CW-1:0] ONE  = CW'(1);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] READ  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   logic [1:0]            state;
   logic                  gport;
   logic [CW-1:0]         len;
   logic [CW-1:0]         remaining;
   logic                  pend_v;
   logic                  pend_port;
   logic                  pend_first;
   logic                  pend_last;
   logic [DATA_WIDTH-1:0] buf_data [2];
   logic [1:0]            buf_port;
   logic [1:0]            buf_first;
   logic [1:0]            buf_last;
   logic                  rd_ptr;
   logic                  wr_ptr;
   logic [1:0]            occ;
   logic                  elig0;
   logic                  elig1;
   logic                  pick;
   logic [CW-1:0]         gcnt;
   logic [CW-1:0]         glen;
   logic                  credit;
   logic                  rd;
   logic                  pop;
   logic                  head_pop;
   logic                  push;
   logic [DATA_WIDTH-1:0] rdata_sel;
`ifndef FIFO_ARB_FIXED_PRIO_EN
   logic                  last_grant;
`endif

   // Port eligibility and the winner if a grant is made this cycle
   always_comb begin
      elig0 = (cnt0 >= BLEN) || (flush0 && cnt0 != '0);
      elig1 = (cnt1 >= BLEN) || (flush1 && cnt1 != '0);
`ifdef FIFO_ARB_FIXED_PRIO_EN
      pick = !elig0;
`else
      pick = (elig0 && elig1) ? !last_grant : elig1;
`endif
      gcnt = pick ? cnt1 : cnt0;
      glen = (gcnt < BLEN) ? gcnt : BLEN;
   end

   // Read issue: registered state only, limited by buffer credit
   always_comb begin
      credit = ({1'b0, occ} + {2'b00, pend_v}) < 3'd2;
      rd     = nrst && (state == READ) && (remaining != '0) && credit;
      re0    = rd && !gport;
      re1    = rd && gport;
   end

   // Output: buffer head, or returning word bypassed when buffer is empty
   always_comb begin
      rdata_sel = pend_port ? rdata1 : rdata0;
      out_valid = (occ != 2'd0) || pend_v;
      out_data  = '0;
      out_port  = 1'b0;
      out_first = 1'b0;
      out_last  = 1'b0;
      if (occ != 2'd0) begin
         out_data  = buf_data[rd_ptr];
         out_port  = buf_port[rd_ptr];
         out_first = buf_first[rd_ptr];
         out_last  = buf_last[rd_ptr];
      end else if (pend_v) begin
         out_data  = rdata_sel;
         out_port  = pend_port;
         out_first = pend_first;
         out_last  = pend_last;
      end
      pop      = out_valid && out_ready;
      head_pop = pop && (occ != 2'd0);
      push     = pend_v && !(pop && occ == 2'd0);
      busy     = (state != IDLE) || (occ != 2'd0);
   end

   // Grant, burst sequencing and round-robin pointer
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state      <= IDLE;
         gport      <= 1'b0;
         len        <= '0;
         remaining  <= '0;
`ifndef FIFO_ARB_FIXED_PRIO_EN
         last_grant <= 1'b1;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (elig0 || elig1) begin
                  gport      <= pick;
                  len        <= glen;
                  remaining  <= glen;
`ifndef FIFO_ARB_FIXED_PRIO_EN
                  last_grant <= pick;
`endif
                  state      <= READ;
               end
            end
            READ: begin
               if (rd) begin
                  remaining <= remaining - ONE;
                  if (remaining == ONE)
                     state <= DRAIN;
               end
            end
            DRAIN: begin
               if (pop && out_last)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Tag returning read data and keep the 2-entry output buffer
   always_ff @(posedge clk) begin
      if (!nrst) begin
         pend_v     <= 1'b0;
         pend_port  <= 1'b0;
         pend_first <= 1'b0;
         pend_last  <= 1'b0;
         rd_ptr     <= 1'b0;
         wr_ptr     <= 1'b0;
         occ        <= 2'd0;
         buf_port   <= 2'b00;
         buf_first  <= 2'b00;
         buf_last   <= 2'b00;
         for (int i = 0; i < 2; i++)
            buf_data[i] <= '0;
      end else begin
         pend_v     <= rd;
         pend_port  <= gport;
         pend_first <= (remaining == len);
         pend_last  <= (remaining == ONE);
         if (push) begin
            buf_data[wr_ptr]  <= rdata_sel;
            buf_port[wr_ptr]  <= pend_port;
            buf_first[wr_ptr] <= pend_first;
            buf_last[wr_ptr]  <= pend_last;
            wr_ptr            <= !wr_ptr;
         end
         if (head_pop)
            rd_ptr <= !rd_ptr;
         occ <= occ + {1'b0, push} - {1'b0, head_pop};
      end
   end

endmodule

// File: tb/tb_fifo_burst_arbiter.sv
// tb_fifo_burst_arbiter: scoreboard bench with FIFO models and a
// burst-level reference model of the arbitration rules.
module tb_fifo_burst_arbiter;
   localparam int DW = 16;
   localparam int AW = 8;
   localparam int BL = 32;

   typedef struct packed {
      logic [DW-1:0] d;
      logic          p;
      logic          f;
      logic          l;
   } item_t;

   logic          clk = 1'b0;
   logic          nrst = 1'b0;
   logic [AW:0]   cnt0 = '0;
   logic [AW:0]   cnt1 = '0;
   logic          flush0 = 1'b0;
   logic          flush1 = 1'b0;
   logic          re0;
   logic          re1;
   logic [DW-1:0] rdata0 = '0;
   logic [DW-1:0] rdata1 = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic          out_port;
   logic          out_first;
   logic          out_last;
   logic          busy;

   always #5 clk = ~clk;

   fifo_burst_arbiter #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .BURST_LEN (BL)
   ) dut (
      .clk      (clk),
      .nrst     (nrst),
      .cnt0     (cnt0),
      .cnt1     (cnt1),
      .flush0   (flush0),
      .flush1   (flush1),
      .re0      (re0),
      .re1      (re1),
      .rdata0   (rdata0),
      .rdata1   (rdata1),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_port (out_port),
      .out_first(out_first),
      .out_last (out_last),
      .busy     (busy)
   );

   item_t         sb[$];
   logic [DW-1:0] q0[$], q1[$], ld0[$], ld1[$];
   logic [DW-1:0] mq0[$], mq1[$];
   logic          fl0_req = 1'b0;
   logic          fl1_req = 1'b0;
   int            lg = 1;
   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   int            load_cyc = 0;
   int            re_first = 0;
   int            re_last = 0;
   int            re_n = 0;
   int            rd_tot = 0;
   int            hs_n = 0;
   int            fst_cyc = -1;
   int            lst_cyc = -1;
   logic          gap_chk = 1'b0;
   logic          stall = 1'b0;
   item_t         held;
   item_t         got;
   item_t         exp_i;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", nm, act, exp);
      end
   endtask

   // FIFO models: rdata one cycle after re, occupancy one cycle after re
   always @(posedge clk) begin
      cyc++;
      if (!nrst) begin
         q0.delete();
         q1.delete();
         cnt0   <= '0;
         cnt1   <= '0;
         rdata0 <= '0;
         rdata1 <= '0;
         flush0 <= 1'b0;
         flush1 <= 1'b0;
         rd_tot = 0;
      end else begin
         if (re0 || re1) begin
            if (re_n == 0) re_first = cyc - 1;
            re_last = cyc - 1;
            re_n++;
            rd_tot++;
         end
         if (re0 && re1) chk("both_re", 1, 0);
         if (re0) begin
            chk("re0_nonempty", q0.size() > 0, 1);
            if (q0.size() > 0) rdata0 <= q0.pop_front();
         end
         if (re1) begin
            chk("re1_nonempty", q1.size() > 0, 1);
            if (q1.size() > 0) rdata1 <= q1.pop_front();
         end
         if (ld0.size() > 0 || ld1.size() > 0) load_cyc = cyc;
         while (ld0.size() > 0) q0.push_back(ld0.pop_front());
         while (ld1.size() > 0) q1.push_back(ld1.pop_front());
         flush0 <= fl0_req;
         flush1 <= fl1_req;
         cnt0   <= (AW+1)'(q0.size());
         cnt1   <= (AW+1)'(q1.size());
      end
   end

   // Monitor: pop expected word on each handshake, check stability
   always @(negedge clk) begin
      got = {out_data, out_port, out_first, out_last};
      if (!nrst) begin
         stall = 1'b0;
         hs_n  = 0;
      end else begin
         checks++;
         if (rd_tot - hs_n > 2) begin
            errors++;
            $display("FAIL outstanding got %0d want <=2", rd_tot - hs_n);
         end
         if (stall) begin
            checks++;
            if (!out_valid || got != held) begin
               errors++;
               $display("FAIL stable got %0d/%0h want 1/%0h",
                        out_valid, got, held);
            end
         end
         if (out_valid && out_ready) begin
            hs_n++;
            if (out_first) begin
               if (gap_chk && lst_cyc >= 0)
                  chk("burst_gap", cyc - lst_cyc, 3);
               fst_cyc = cyc;
            end
            if (out_last) lst_cyc = cyc;
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_word got %0h want none", got);
            end else begin
               exp_i = sb.pop_front();
               if (got != exp_i) begin
                  errors++;
                  $display("FAIL word got %0h/%0d/%0d/%0d want %0h/%0d/%0d/%0d",
                           got.d, got.p, got.f, got.l,
                           exp_i.d, exp_i.p, exp_i.f, exp_i.l);
               end
            end
         end
         stall = out_valid && !out_ready;
         held  = got;
      end
   end

   // Reference: serve bursts until no port is eligible
   task automatic gen_expected(input logic f0, input logic f1);
      logic e0, e1;
      int   p, n;
      forever begin
         e0 = mq0.size() >= BL || (f0 && mq0.size() > 0);
         e1 = mq1.size() >= BL || (f1 && mq1.size() > 0);
         if (!e0 && !e1) break;
`ifdef FIFO_ARB_FIXED_PRIO_EN
         p = e0 ? 0 : 1;
`else
         if (e0 && e1) p = (lg == 0) ? 1 : 0;
         else p = e1 ? 1 : 0;
`endif
         lg = p;
         n = (p == 0) ? mq0.size() : mq1.size();
         if (n > BL) n = BL;
         for (int k = 0; k < n; k++) begin
            item_t it;
            it.d = (p == 0) ? mq0.pop_front() : mq1.pop_front();
            it.p = (p == 1);
            it.f = (k == 0);
            it.l = (k == n - 1);
            sb.push_back(it);
         end
      end
   endtask

   task automatic drive_ready(input int mode);
      case (mode)
         0:       out_ready = 1'b1;
         1:       out_ready = ($urandom_range(0, 1) == 1);
         default: out_ready = ($urandom_range(0, 3) == 0);
      endcase
   endtask

   task automatic load(input int n0, input int n1,
                       input logic f0, input logic f1);
      logic [DW-1:0] d;
      for (int k = 0; k < n0; k++) begin
         d = DW'($urandom);
         mq0.push_back(d);
         ld0.push_back(d);
      end
      for (int k = 0; k < n1; k++) begin
         d = DW'($urandom);
         mq1.push_back(d);
         ld1.push_back(d);
      end
      fl0_req = f0;
      fl1_req = f1;
      gen_expected(f0, f1);
   endtask

   task automatic run_phase(input int n0, input int n1, input logic f0,
                            input logic f1, input int mode);
      load(n0, n1, f0, f1);
      for (int i = 0; i < 3000; i++) begin
         drive_ready(mode);
         @(posedge clk);
         #1;
         if (i > 4 && sb.size() == 0 && !busy) break;
      end
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("phase_drained", sb.size(), 0);
      chk("phase_idle", busy, 0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_re0", re0, 0);
      chk("rst_re1", re1, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_port", out_port, 0);
      chk("rst_first", out_first, 0);
      chk("rst_last", out_last, 0);
      chk("rst_busy", busy, 0);
      nrst = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      re_n = 0;
      run_phase(40, 0, 1'b0, 1'b0, 0);
      chk("a_re_count", re_n, 32);
      chk("a_re_contig", re_last - re_first, 31);
      chk("a_grant_lat", re_first - load_cyc, 1);
      chk("a_valid_lat", fst_cyc - load_cyc, 2);
      chk("a_last_word", lst_cyc - load_cyc, 33);

      gap_chk = 1'b1;
      lst_cyc = -1;
      run_phase(56, 64, 1'b0, 1'b0, 0);
      gap_chk = 1'b0;

      re_n = 0;
      run_phase(0, 5, 1'b0, 1'b0, 0);
      chk("c_no_grant", re_n, 0);
      run_phase(0, 0, 1'b0, 1'b1, 0);
      chk("c_flush_reads", re_n, 5);

      for (int ph = 0; ph < 20; ph++)
         run_phase($urandom_range(0, 70), $urandom_range(0, 70),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 2));

      run_phase(0, 0, 1'b1, 1'b1, 0);
      load(40, 0, 1'b0, 1'b0);
      out_ready = 1'b1;
      base = hs_n;
      for (int i = 0; i < 300 && hs_n - base < 10; i++)
         @(posedge clk);
      #1;
      chk("r_reach_word10", hs_n - base, 10);
      nrst = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      chk("r_cycle_re", {re0, re1}, 0);
      @(posedge clk);
      #1;
      chk("r_re", {re0, re1}, 0);
      chk("r_valid", out_valid, 0);
      chk("r_data", out_data, 0);
      chk("r_tags", {out_port, out_first, out_last}, 0);
      chk("r_busy", busy, 0);
      sb.delete();
      mq0.delete();
      mq1.delete();
      ld0.delete();
      ld1.delete();
      lg = 1;
      fl0_req = 1'b0;
      fl1_req = 1'b0;
      @(posedge clk);
      #1;
      nrst = 1'b1;
      run_phase(32, 0, 1'b0, 1'b0, 0);
      run_phase(32, 32, 1'b0, 1'b0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
